// File: rtl/rr_mux.sv
// N-input registered multiplexer with valid/ready handshakes.
// Arbitration is round-robin (mode=0) or fixed lowest-index priority (mode=1).
module rr_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [((N > 2) ? $clog2(N) : 1)-1:0] out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned SW = (N > 2) ? $clog2(N) : 1;

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt_idx;
    logic          gnt_found;
    logic          load;
    logic          in_xfer;

    // Reset also blocks acceptance so no input sees ready while held in reset.
    assign load    = rst_n && (!out_valid || out_ready);
    assign in_xfer = load && gnt_found;

    // Grant search; iterating from the far end lets the first match in search order win.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        if (mode) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SW'(i);
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[(int'(ptr) + k) % int'(N)]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = SW'((int'(ptr) + k) % int'(N));
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (in_xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (in_xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
                out_sel   <= gnt_idx;
                if (!mode) begin
                    ptr <= (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes and selectable round-robin or fixed-priority arbitration. Successor to the 2:1 combinational `mux` gate. It merges several producer streams onto one consumer through a single-entry output register. It sits in the gates library as the first sequential selection primitive.

## Interface
- `WIDTH`, 8: data width per channel, ≥1.
- `N`, 4: number of input channels, ≥2.
- `SW`, derived (localparam) = max(1, $clog2(N)): channel-index width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  1  0 = round-robin, 1 = fixed priority (lowest index wins). Sampled every cycle.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; one-hot or zero.
- `out_data`  out  WIDTH  registered selected data.
- `out_sel`  out  SW  registered index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- State: output register (`out_data`, `out_sel`, `out_valid`) and round-robin pointer `ptr` (SW bits, range 0..N-1).
- `load` = !out_valid || out_ready. The register can accept a new word this cycle, including on the same cycle the current word drains.
- Grant, combinational:
  - mode 0: first i with in_valid[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - mode 1: lowest i with in_valid[i]=1.
  - No valid input: no grant.
- `in_ready[i]` = load && grant==i. At most one bit is set. It never depends on in_valid of other channels beyond arbitration.
- Input transfer on channel i when in_valid[i] && in_ready[i]. On that edge:
  - out_data ← channel i data
  - out_sel ← i
  - out_valid ← 1
- Output transfer when out_valid && out_ready. If there is no simultaneous input transfer, out_valid ← 0. out_data and out_sel hold their last values.
- Simultaneous output and input transfer: the register is overwritten with the new word and out_valid stays 1. This gives full throughput, one word per cycle.
- Pointer:
  - Updates only on an input transfer in mode 0: ptr ← (granted i + 1) mod N, wrapping N-1 → 0.
  - Mode 1 transfers leave ptr unchanged.
  - Switching mode takes effect on the same cycle's grant.
- Output stable while stalled: while out_valid && !out_ready, out_data/out_sel/out_valid hold and all in_ready = 0.
- Inputs are expected to hold data/valid until accepted. The block does not check this.

## Timing
- Reset (rst_n=0, asynchronous, effective immediately): out_valid=0, out_data=0, out_sel=0, ptr=0.
- While rst_n=0, all in_ready=0. Reset asserted mid-transfer drops the held word with no output transfer.
- First in_ready can assert in the first cycle after rst_n deasserts.
- Latency: an input accepted at edge k appears on out_data with out_valid=1 after edge k (1 cycle).
- Throughput: 1 word/cycle when out_ready=1 continuously.
- Fairness, mode 0 with all N channels continuously valid and out_ready=1: grants cycle 0,1,…,N-1,0,… Each channel waits at most N-1 transfers.
- Mode 1 gives no fairness guarantee; channel 0 can starve the others.
- No combinational path from in_data to out_data. Combinational paths: in_valid, out_ready, mode → in_ready.

## Test plan
- Reset:
  - Assert rst_n=0 asynchronously mid-cycle while out_valid=1 → out_valid, out_data, out_sel drop to 0 immediately and all in_ready=0.
  - After release with in_valid=4'b0100 → in_ready=4'b0100, and the word appears with out_sel=2 one cycle later.
- Round-robin rotation:
  - N=4, mode 0, in_valid=4'b1111 steady, data ch i = 8'hA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0,1 with out_data A0,A1,A2,A3,A0,A1 on consecutive cycles.
  - Pointer wraps after channel 3.
- Fixed priority:
  - mode 1, in_valid=4'b1010 for 3 cycles → out_sel=1 each cycle and ptr unchanged.
  - Drop in_valid[1] → out_sel=3.
- Backpressure:
  - out_ready=0 for 5 cycles with out_valid=1 → out_data/out_sel constant and in_ready=0.
  - Raise out_ready → the held word drains and the next granted word loads on the same edge, with no bubble.
- Mode switch:
  - mode 0, ptr=2, in_valid=4'b0011 → grant 0.
  - Same cycle with mode=1 → grant 0.
  - With ptr=1, mode 0 → grant 1.
- Parameter sweep:
  - N=2, WIDTH=1 behaves as a registered 2:1 mux: in_valid=2'b11 alternates out_sel 0,1.
  - N=5, WIDTH=16: ptr wraps 4 → 0 and all channels are served.
